// File: rtl/arb_pkg.sv
// Shared definitions for the register bank arbiter.
// Contents:
//   arb_state_e   - FSM state encoding (IDLE, GRANT, RELEASE)
//   N_REQ_DEF     - default number of requesters
//   DATA_W_DEF    - default bank data width
//   onehot_to_idx - binary index of a one-hot vector (up to OH_W bits)
package arb_pkg;

    localparam int unsigned N_REQ_DEF  = 3;
    localparam int unsigned DATA_W_DEF = 48;
    localparam int unsigned OH_W       = 32;
    localparam int unsigned IDX_W      = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

    // ORing the indices of set bits yields the index for a one-hot input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [OH_W-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < OH_W; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection.
// Ports:
//   req  - per-port request vector
//   last - index of the last-served port
//   pick - one-hot winner: first requesting port after 'last', wrapping;
//          all zero when nothing requests
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] last,
    output logic [N_REQ-1:0] pick
);

    always_comb begin
        int unsigned cand;
        logic        found;
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        // Walk offsets 1..N_REQ from the pointer; offset N_REQ is the
        // last-served port itself, so it only wins when it is alone.
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = 32'(last) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && (i == cand) && req[i]) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/register_bank_arbiter.sv
// Round-robin arbiter sharing the data_registers bank among requesters
// (port 0 memory controller, port 1 transaction datapath, port 2 display).
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   req/wr/acc_type  - per-port request, write strobe, access type
//   wdata            - per-port write data, port i at [i*DATA_W +: DATA_W]
//   gnt              - one-hot grant
//   rvalid           - one-cycle read-valid pulse to the owner
//   rdata            - registered bank result
//   forced           - sticky per-port forced-release flag
//   reg_wren/reg_access_type/reg_data_in - registered drive into the bank
//   reg_result       - bank result
//   busy             - FSM not in IDLE
module register_bank_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        wr,
    input  logic [N_REQ-1:0]        acc_type,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        forced,
    output logic                    reg_wren,
    output logic                    reg_access_type,
    output logic [DATA_W-1:0]       reg_data_in,
    input  logic [DATA_W-1:0]       reg_result,
    output logic                    busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [N_REQ-1:0]  forced_q, forced_d;
    logic              wren_q, wren_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic [N_REQ-1:0]  pick;
    logic [DATA_W-1:0] wdata_arr [N_REQ];
    logic              own_req, own_wr, own_acc;
    logic [DATA_W-1:0] own_wdata;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req  (req),
        .last (ptr_q),
        .pick (pick)
    );

    // While granted the pointer already names the owner, so it selects the mux.
    always_comb begin
        own_req   = 1'b0;
        own_wr    = 1'b0;
        own_acc   = 1'b0;
        own_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                own_req   = req[i];
                own_wr    = wr[i];
                own_acc   = acc_type[i];
                own_wdata = wdata_arr[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        forced_d = forced_q;
        wren_d   = wren_q;
        acc_d    = acc_q;
        din_d    = din_q;
        unique case (state_q)
            IDLE: begin
                wren_d = 1'b0;
                hold_d = '0;
                if (|req) begin
                    gnt_d   = pick;
                    ptr_d   = PTR_W'(onehot_to_idx(OH_W'(pick)));
                    state_d = GRANT;
                end
            end
            GRANT: begin
                wren_d  = own_wr;
                acc_d   = own_acc;
                din_d   = own_wdata;
                rdata_d = reg_result;
                if (!own_wr) begin
                    rvalid_d = gnt_q;
                end
                hold_d = hold_q + HOLD_W'(1);
                if (!own_req) begin
                    gnt_d   = '0;
                    state_d = RELEASE;
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    forced_d = forced_q | gnt_q;
                    gnt_d    = '0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                gnt_d   = '0;
                wren_d  = 1'b0;
                hold_d  = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                wren_d  = 1'b0;
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= PTR_W'(N_REQ - 1);
            hold_q   <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            forced_q <= '0;
            wren_q   <= 1'b0;
            acc_q    <= 1'b0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            forced_q <= forced_d;
            wren_q   <= wren_d;
            acc_q    <= acc_d;
            din_q    <= din_d;
        end
    end

    assign gnt             = gnt_q;
    assign rvalid          = rvalid_q;
    assign rdata           = rdata_q;
    assign forced          = forced_q;
    assign reg_wren        = wren_q;
    assign reg_access_type = acc_q;
    assign reg_data_in     = din_q;
    assign busy            = (state_q != IDLE);

endmodule
